// File: rtl/design_variables.sv
// Shared traceback encodings and FSM state type; source codes match the PE/max-cell encoding.
// TRACEBACK_ERR_CHECK_EN (optional) makes source 2'b11 a reportable error instead of a diagonal move.
package design_variables;

    localparam int SOURCE_WIDTH = 2;

    localparam logic [SOURCE_WIDTH-1:0] SRC_DIAG    = 2'b00;
    localparam logic [SOURCE_WIDTH-1:0] SRC_TOP     = 2'b01;
    localparam logic [SOURCE_WIDTH-1:0] SRC_LEFT    = 2'b10;
    localparam logic [SOURCE_WIDTH-1:0] SRC_INVALID = 2'b11;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        READ = 3'd1,
        WAIT = 3'd2,
        EMIT = 3'd3,
        DONE = 3'd4
    } tb_state_e;

endpackage

// File: rtl/tb_step.sv
// Next traceback cell from the current cell and its source direction, plus matrix-exit flag.
// Latency: combinational. Backpressure: none (pure function).
// Flow control: n/a.
module tb_step
    import design_variables::*;
#(
    parameter int ROW_W = 5,
    parameter int COL_W = 5
) (
    input  logic [ROW_W-1:0]        row,
    input  logic [COL_W-1:0]        col,
    input  logic [SOURCE_WIDTH-1:0] dir,
    output logic [ROW_W-1:0]        nxt_row,
    output logic [COL_W-1:0]        nxt_col,
    output logic                    oob
);

    always_comb begin
        nxt_row = row;
        nxt_col = col;
        oob     = 1'b0;
        case (dir)
            SRC_TOP: begin
                nxt_row = row - ROW_W'(1);
                oob     = (row == '0);
            end
            SRC_LEFT: begin
                nxt_col = col - COL_W'(1);
                oob     = (col == '0);
            end
            // SRC_DIAG, and 2'b11 whenever it reaches here, moves diagonally
            default: begin
                nxt_row = row - ROW_W'(1);
                nxt_col = col - COL_W'(1);
                oob     = (row == '0) || (col == '0);
            end
        endcase
    end

endmodule

// File: rtl/traceback_engine.sv
// Walks the traceback memory from the max-score cell, streaming one path step per accepted handshake.
// Latency: 3 cycles per step minimum (READ, WAIT, EMIT); out_valid holds with stable data while out_ready is low.
// Optional macro TRACEBACK_ERR_CHECK_EN: source 2'b11 ends the walk with err set.
module traceback_engine
    import design_variables::*;
#(
    parameter int N_QUERY = 32,
    parameter int N_DB    = 32,
    parameter int ROW_W   = $clog2(N_QUERY),
    parameter int COL_W   = $clog2(N_DB)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [ROW_W-1:0]         start_row,
    input  logic [COL_W-1:0]         start_col,
    output logic                     rd_en,
    output logic [ROW_W-1:0]         rd_row,
    output logic [COL_W-1:0]         rd_col,
    input  logic [SOURCE_WIDTH-1:0]  rd_source,
    input  logic                     rd_zero,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [SOURCE_WIDTH-1:0]  out_dir,
    output logic [ROW_W-1:0]         out_row,
    output logic [COL_W-1:0]         out_col,
    output logic                     busy,
    output logic                     done,
    output logic [ROW_W+COL_W:0]     path_len,
    output logic                     err
);

    localparam int LEN_W = ROW_W + COL_W + 1;

    tb_state_e               state;
    logic [ROW_W-1:0]        cur_row;
    logic [COL_W-1:0]        cur_col;
    logic [SOURCE_WIDTH-1:0] dir_q;
    logic [LEN_W-1:0]        len_q;
    logic [ROW_W-1:0]        nxt_row;
    logic [COL_W-1:0]        nxt_col;
    logic                    nxt_oob;

    tb_step #(
        .ROW_W (ROW_W),
        .COL_W (COL_W)
    ) u_step (
        .row     (cur_row),
        .col     (cur_col),
        .dir     (dir_q),
        .nxt_row (nxt_row),
        .nxt_col (nxt_col),
        .oob     (nxt_oob)
    );

`ifdef TRACEBACK_ERR_CHECK_EN
    logic err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (state == IDLE && start) begin
            err_q <= 1'b0;
        end else if (state == WAIT && !rd_zero && rd_source == SRC_INVALID) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cur_row <= '0;
            cur_col <= '0;
            dir_q   <= SRC_DIAG;
            len_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        cur_row <= start_row;
                        cur_col <= start_col;
                        len_q   <= '0;
                        state   <= READ;
                    end
                end
                READ: state <= WAIT;
                WAIT: begin
                    if (rd_zero) begin
                        state <= DONE;
`ifdef TRACEBACK_ERR_CHECK_EN
                    end else if (rd_source == SRC_INVALID) begin
                        state <= DONE;
                    end else begin
                        dir_q <= rd_source;
                        state <= EMIT;
                    end
`else
                    end else begin
                        dir_q <= (rd_source == SRC_INVALID) ? SRC_DIAG : rd_source;
                        state <= EMIT;
                    end
`endif
                end
                EMIT: begin
                    if (out_ready) begin
                        len_q <= len_q + LEN_W'(1);
                        if (nxt_oob) begin
                            state <= DONE;
                        end else begin
                            cur_row <= nxt_row;
                            cur_col <= nxt_col;
                            state   <= READ;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Read address is gated so the memory port idles at zero outside READ
    assign rd_en     = (state == READ);
    assign rd_row    = rd_en ? cur_row : '0;
    assign rd_col    = rd_en ? cur_col : '0;
    assign out_valid = (state == EMIT);
    assign out_dir   = dir_q;
    assign out_row   = cur_row;
    assign out_col   = cur_col;
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign path_len  = len_q;

endmodule

// File: tb/tb_traceback_engine.sv
// Directed-vector bench for traceback_engine: a memory model answers reads, a scoreboard queue
// holds expected path steps and a monitor compares every handshaked step.
module tb_traceback_engine;
    import design_variables::*;

    localparam int RW = 5;
    localparam int CW = 5;

    typedef struct packed {
        logic [1:0]    dir;
        logic [RW-1:0] row;
        logic [CW-1:0] col;
    } step_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [RW-1:0] start_row = '0;
    logic [CW-1:0] start_col = '0;
    logic          rd_en;
    logic [RW-1:0] rd_row;
    logic [CW-1:0] rd_col;
    logic [1:0]    rd_source = 2'b00;
    logic          rd_zero = 1'b1;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [1:0]    out_dir;
    logic [RW-1:0] out_row;
    logic [CW-1:0] out_col;
    logic          busy;
    logic          done;
    logic [RW+CW:0] path_len;
    logic          err;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int last_rd = -1;
    int out_seen = 0;
    int t_done;

    logic [1:0] mem_src  [32][32];
    logic       mem_zero [32][32];
    logic          pend = 1'b0;
    logic [RW-1:0] prow;
    logic [CW-1:0] pcol;
    step_t exp_q[$];
    step_t mon_e;

    traceback_engine dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .start_row (start_row),
        .start_col (start_col),
        .rd_en     (rd_en),
        .rd_row    (rd_row),
        .rd_col    (rd_col),
        .rd_source (rd_source),
        .rd_zero   (rd_zero),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_dir   (out_dir),
        .out_row   (out_row),
        .out_col   (out_col),
        .busy      (busy),
        .done      (done),
        .path_len  (path_len),
        .err       (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Memory model: request seen in READ, data driven just after the edge that enters WAIT
    always @(negedge clk) begin
        if (rd_en) begin
            pend    = 1'b1;
            prow    = rd_row;
            pcol    = rd_col;
            last_rd = cyc;
        end else begin
            pend = 1'b0;
        end
    end

    always @(posedge clk) begin
        #1;
        if (pend) begin
            rd_source = mem_src[prow][pcol];
            rd_zero   = mem_zero[prow][pcol];
        end
    end

    // Scoreboard monitor
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            out_seen++;
            if (out_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL step_unexpected: got step (%0d,%0d) dir %0d, expected none",
                             out_row, out_col, out_dir);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("step_dir", int'(out_dir), int'(mon_e.dir));
                    check("step_row", int'(out_row), int'(mon_e.row));
                    check("step_col", int'(out_col), int'(mon_e.col));
                end
            end
        end
    end

    task automatic mem_clear();
        for (int r = 0; r < 32; r++) begin
            for (int c = 0; c < 32; c++) begin
                mem_src[r][c]  = SRC_DIAG;
                mem_zero[r][c] = 1'b1;
            end
        end
    endtask

    task automatic set_cell(input int r, input int c, input logic [1:0] s);
        mem_src[r][c]  = s;
        mem_zero[r][c] = 1'b0;
    endtask

    task automatic push_step(input logic [1:0] d, input int r, input int c);
        step_t s;
        s.dir = d;
        s.row = RW'(r);
        s.col = CW'(c);
        exp_q.push_back(s);
    endtask

    task automatic pulse_start(input int r, input int c);
        @(posedge clk);
        #1;
        start     = 1'b1;
        start_row = RW'(r);
        start_col = CW'(c);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, output int td);
        td = -1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (done) begin
                td = cyc;
                return;
            end
        end
        total++;
        bad++;
        $display("FAIL %s_timeout: got no done, expected done within 400 cycles", name);
    endtask

    task automatic wait_valid(input string name);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (out_valid) return;
        end
        total++;
        bad++;
        $display("FAIL %s_timeout: got no out_valid, expected out_valid within 100 cycles", name);
    endtask

    task automatic finish_trace(input string name, input int exp_len, input int exp_err);
        wait_done(name, t_done);
        check({name, "_path_len"}, int'(path_len), exp_len);
        check({name, "_err"}, int'(err), exp_err);
        check({name, "_queue_left"}, exp_q.size(), 0);
        @(negedge clk);
        check({name, "_done_one_cycle"}, int'(done), 0);
        check({name, "_idle_busy"}, int'(busy), 0);
        check({name, "_len_hold"}, int'(path_len), exp_len);
    endtask

    task automatic run_trace(input string name, input int r, input int c,
                             input int exp_len, input int exp_err);
        out_seen = 0;
        pulse_start(r, c);
        finish_trace(name, exp_len, exp_err);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, expected finish");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        mem_clear();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_rd_en", int'(rd_en), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_path_len", int'(path_len), 0);
        check("rst_err", int'(err), 0);
        rst_n = 1'b1;

        // Diagonal walk ending on a zero cell at (0,0)
        mem_clear();
        set_cell(3, 3, SRC_DIAG);
        set_cell(2, 2, SRC_DIAG);
        set_cell(1, 1, SRC_DIAG);
        push_step(SRC_DIAG, 3, 3);
        push_step(SRC_DIAG, 2, 2);
        push_step(SRC_DIAG, 1, 1);
        run_trace("diag", 3, 3, 3, 0);

        // LEFT, LEFT, TOP then zero at (1,3)
        mem_clear();
        set_cell(2, 5, SRC_LEFT);
        set_cell(2, 4, SRC_LEFT);
        set_cell(2, 3, SRC_TOP);
        push_step(SRC_LEFT, 2, 5);
        push_step(SRC_LEFT, 2, 4);
        push_step(SRC_TOP, 2, 3);
        run_trace("left_top", 2, 5, 3, 0);

        // Zero start cell: no step, done two cycles after READ
        mem_clear();
        run_trace("zero_start", 7, 7, 0, 0);
        check("zero_start_no_valid", out_seen, 0);
        check("zero_start_done_gap", t_done - last_rd, 2);

        // TOP from row 0 leaves the matrix after one step
        mem_clear();
        set_cell(0, 4, SRC_TOP);
        push_step(SRC_TOP, 0, 4);
        run_trace("row0_top", 0, 4, 1, 0);

        // Stall in EMIT with a start pulse that must be ignored
        mem_clear();
        set_cell(4, 4, SRC_DIAG);
        push_step(SRC_DIAG, 4, 4);
        out_ready = 1'b0;
        pulse_start(4, 4);
        wait_valid("stall");
        start     = 1'b1;
        start_row = RW'(9);
        start_col = CW'(9);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_valid", int'(out_valid), 1);
            check("stall_row", int'(out_row), 4);
            check("stall_col", int'(out_col), 4);
            check("stall_dir", int'(out_dir), int'(SRC_DIAG));
            check("stall_len", int'(path_len), 0);
        end
        start     = 1'b0;
        out_ready = 1'b1;
        finish_trace("stall", 1, 0);

        // Source 2'b11
        mem_clear();
        set_cell(6, 6, SRC_INVALID);
`ifdef TRACEBACK_ERR_CHECK_EN
        run_trace("bad_src", 6, 6, 0, 1);
        check("bad_src_no_valid", out_seen, 0);
`else
        push_step(SRC_DIAG, 6, 6);
        run_trace("bad_src", 6, 6, 1, 0);
`endif

        // A following start clears err
        mem_clear();
        set_cell(2, 5, SRC_LEFT);
        push_step(SRC_LEFT, 2, 5);
        run_trace("after_err", 2, 5, 1, 0);

        // Reset while a step is pending in EMIT
        mem_clear();
        set_cell(5, 5, SRC_DIAG);
        set_cell(4, 4, SRC_DIAG);
        push_step(SRC_DIAG, 5, 5);
        out_ready = 1'b0;
        pulse_start(5, 5);
        wait_valid("mid_rst");
        rst_n = 1'b0;
        #1;
        check("mid_rst_rd_en", int'(rd_en), 0);
        check("mid_rst_out_valid", int'(out_valid), 0);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_done", int'(done), 0);
        check("mid_rst_err", int'(err), 0);
        check("mid_rst_path_len", int'(path_len), 0);
        check("mid_rst_out_dir", int'(out_dir), 0);
        check("mid_rst_out_row", int'(out_row), 0);
        check("mid_rst_out_col", int'(out_col), 0);
        check("mid_rst_rd_row", int'(rd_row), 0);
        check("mid_rst_rd_col", int'(rd_col), 0);
        exp_q.delete();
        repeat (2) @(negedge clk);

        // First edge after reset release accepts start
        mem_clear();
        set_cell(1, 0, SRC_LEFT);
        push_step(SRC_LEFT, 1, 0);
        out_ready = 1'b1;
        out_seen  = 0;
        rst_n     = 1'b1;
        start     = 1'b1;
        start_row = RW'(1);
        start_col = CW'(0);
        @(posedge clk);
        #1;
        start = 1'b0;
        check("post_rst_busy", int'(busy), 1);
        finish_trace("post_rst", 1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/traceback_engine.md
TRACEBACK_ENGINE -- requirements
Module: traceback_engine

Interface
REQ-001 Parameter N_QUERY, default 32, SHALL set the number of matrix rows (query letters).
REQ-002 Parameter N_DB, default 32, SHALL set the number of matrix columns (database letters).
REQ-003 Parameter ROW_W, default $clog2(N_QUERY), SHALL set the row index width; COL_W, default $clog2(N_DB), SHALL set the column index width.
REQ-004 clk  in  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-005 rst_n  in  1  SHALL be the asynchronous, active-low reset.
REQ-006 start  in  1  SHALL request a traceback; sampled only in IDLE.
REQ-007 start_row / start_col  in  ROW_W / COL_W  SHALL give the max-score cell coordinates, sampled with start.
REQ-008 rd_en  out  1; rd_row / rd_col  out  ROW_W / COL_W  SHALL form the traceback-memory read request.
REQ-009 rd_source  in  SOURCE_WIDTH; rd_zero  in  1  SHALL return the stored PE source and zero_score_bit exactly one cycle after rd_en.
REQ-010 out_valid  out  1; out_ready  in  1; out_dir  out  SOURCE_WIDTH; out_row / out_col  out  ROW_W / COL_W  SHALL form the path-step stream.
REQ-011 busy  out  1; done  out  1; path_len  out  ROW_W+COL_W+1; err  out  1  SHALL give status.

Function
REQ-012 The FSM SHALL have states IDLE, READ, WAIT, EMIT, DONE.
REQ-013 IDLE: start=1 SHALL latch the coordinates into cur_row/cur_col, clear path_len, and enter READ next cycle.
REQ-014 READ: rd_en=1 for exactly one cycle with rd_row=cur_row and rd_col=cur_col; next state WAIT.
REQ-015 WAIT: if rd_zero=1, next state DONE with no step emitted; otherwise latch rd_source and enter EMIT.
REQ-016 EMIT: out_valid=1 with out_dir/out_row/out_col held stable until out_ready=1; a step transfers only when out_valid and out_ready are both high.
REQ-017 On transfer, path_len SHALL increment by 1 and the next cell SHALL be: SRC_DIAG -> (row-1, col-1); SRC_TOP -> (row-1, col); SRC_LEFT -> (row, col-1).
REQ-018 If the next cell would leave the matrix (decrement of a zero index), next state SHALL be DONE; otherwise READ.
REQ-019 DONE: done=1 for exactly one cycle, then IDLE; path_len SHALL hold its value until the next accepted start.
REQ-020 busy SHALL be 1 in every state except IDLE.
REQ-021 start while busy=1 SHALL be ignored.
REQ-022 Minimum step throughput SHALL be one step per 3 cycles (READ, WAIT, EMIT with out_ready=1).
REQ-023 path_len SHALL never wrap; its width covers the longest path, N_QUERY+N_DB-1.

Reset
REQ-024 rst_n=0 SHALL immediately force IDLE and set rd_en, out_valid, busy, done, err, path_len, out_dir, out_row, out_col, rd_row and rd_col to 0, including mid-traceback.
REQ-025 The first start SHALL be accepted on the first rising edge after rst_n deasserts.

Configuration
REQ-026 Macro TRACEBACK_ERR_CHECK_EN defined: in WAIT, rd_source=2'b11 with rd_zero=0 SHALL skip EMIT, go to DONE, and set err=1 until the next accepted start; err SHALL clear on that start.
REQ-027 Macro TRACEBACK_ERR_CHECK_EN undefined: 2'b11 SHALL be treated as SRC_DIAG and err SHALL be tied to 0.

Structure
REQ-028 SOURCE_WIDTH and the encodings SRC_DIAG=2'b00, SRC_TOP=2'b01, SRC_LEFT=2'b10 SHALL live in design_variables and match the max/PE source encoding.
REQ-029 The FSM state enum SHALL live in design_variables.
REQ-030 One sub-module, tb_step, SHALL hold the combinational next-coordinate and out-of-bounds computation; there are no other sub-modules.

Verification
REQ-031 Start (3,3) with diagonal sources down to a zero cell at (0,0) -> three steps (3,3),(2,2),(1,1); done; path_len=3.
REQ-032 Start (2,5) with LEFT,LEFT,TOP then a zero cell -> steps (2,5),(2,4),(2,3); path_len=3; err=0.
REQ-033 Start cell with rd_zero=1 -> no out_valid; done 2 cycles after READ; path_len=0.
REQ-034 Start (0,4) with SRC_TOP -> one step emitted, then done (boundary exit); path_len=1.
REQ-035 out_ready held low 5 cycles in EMIT -> outputs stable, path_len unchanged; a start pulse during busy is ignored.
REQ-036 rst_n low mid-EMIT -> all outputs 0 in the same cycle; with TRACEBACK_ERR_CHECK_EN, source 2'b11 -> err=1 and done with no step emitted.
